traffic_sensor_conditioner: RTL

Upstream front end for the traffic-light controller FSM. It takes the raw, asynchronous road sensors for street A and street B and does three things: synchronizes them to clk, debounces them, and produces the clean SA/SB levels the FSM consumes. It also generates the slow one-cycle tick that paces the FSM's state advances.

---
 rtl/traffic_sensor_pkg.sv | 17 +
 rtl/sensor_debounce.sv | 46 ++++
 rtl/traffic_sensor_conditioner.sv | 97 +++++++++
 3 files changed

// File: rtl/traffic_sensor_pkg.sv
// Shared constants and width helpers for the traffic sensor front end.
package traffic_sensor_pkg;

  localparam int DIV_DEFAULT         = 7500000;
  localparam int DB_CYCLES_DEFAULT   = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // The counter must be able to hold values up to db_cycles.
  function automatic int deb_cnt_width(input int db_cycles);
    return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
  endfunction

  function automatic int tick_cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: SYNC_STAGES-deep synchronizer followed by a
// consecutive-sample debounce counter producing a clean level.
module sensor_debounce
  import traffic_sensor_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = deb_cnt_width(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  // Any sample agreeing with the current level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      level <= sync;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Sensor conditioner for the traffic-light FSM: debounced SA/SB plus a
// divided tick. Define TRAFFIC_SENSOR_LATCH_EN to hold SA/SB per tick period.
module traffic_sensor_conditioner
  import traffic_sensor_pkg::*;
#(
  parameter int DIV         = DIV_DEFAULT,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sa_raw,
  input  logic sb_raw,
  output logic tick,
  output logic SA,
  output logic SB
);

  localparam int TW = tick_cnt_width(DIV);

  logic          deb_a;
  logic          deb_b;
  logic [TW-1:0] tcnt;

  sensor_debounce #(
    .DB_CYCLES  (DB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deb_a (
    .clk  (clk),
    .reset(reset),
    .raw  (sa_raw),
    .level(deb_a)
  );

  sensor_debounce #(
    .DB_CYCLES  (DB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deb_b (
    .clk  (clk),
    .reset(reset),
    .raw  (sb_raw),
    .level(deb_b)
  );

  // tick is registered one count early so it is high while tcnt == DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tcnt <= (tcnt == TW'(DIV - 1)) ? '0 : tcnt + TW'(1);
      tick <= (tcnt == TW'(DIV - 2));
    end
  end

`ifdef TRAFFIC_SENSOR_LATCH_EN
  logic deb_a_d;
  logic deb_b_d;
  logic rise_a;
  logic rise_b;
  logic pend_a;
  logic pend_b;
  logic sa_q;
  logic sb_q;

  assign rise_a = deb_a & ~deb_a_d;
  assign rise_b = deb_b & ~deb_b_d;

  // A rise coinciding with tick goes straight into that tick's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_a_d <= 1'b0;
      deb_b_d <= 1'b0;
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      deb_a_d <= deb_a;
      deb_b_d <= deb_b;
      pend_a  <= tick ? 1'b0 : (pend_a | rise_a);
      pend_b  <= tick ? 1'b0 : (pend_b | rise_b);
      if (tick) begin
        sa_q <= deb_a | pend_a | rise_a;
        sb_q <= deb_b | pend_b | rise_b;
      end
    end
  end

  assign SA = sa_q;
  assign SB = sb_q;
`else
  assign SA = deb_a;
  assign SB = deb_b;
`endif

endmodule
